fpu_div_scheduler: RTL
======================

# fpu_div_scheduler

Shares one multi-cycle floating-point divider between two requesters. Arbitrates round-robin, latches the granted operands, pulses the divider start, and waits for the divider ready. Returns the quotient, tagged with the requester id, over a valid/ready response port. It handles divide-by-zero without using the divider and enforces a timeout on a divider that never answers.

## Interface
- X, 32: operand width; 32 (8-bit exponent, 23-bit mantissa) or 64 (11/52).
- TIMEOUT, 64: maximum WAIT cycles before abort; must be ≥ 2.
- clk  in  1  single clock, all state on rising edge.
- clrn  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_a, req0_b / req1_a, req1_b  in  X  dividend, divisor (IEEE-754).
- req0_ready / req1_ready  out  1  operation accepted this cycle (valid & ready).
- div_a, div_b  out  X  operands to divider, held stable from accept until return to IDLE.
- div_start  out  1  one-cycle start pulse to divider.
- div_ready  in  1  divider result valid.
- div_out  in  X  divider quotient.
- div_overflow, div_underflow  in  1  divider status, sampled with div_ready.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index of response.
- rsp_data  out  X  quotient.
- rsp_flags  out  4  {timeout, div_by_zero, overflow, underflow}.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If no reqN_valid is asserted, stay in IDLE.
  - Otherwise grant one requester. If both are valid, grant the one not granted last. last_grant resets to 1, so req0 wins the first tie.
  - Assert reqN_ready combinationally for the granted requester only.
  - On accept: latch a, b and id; update last_grant.
  - Divisor zero (exponent field 0 and mantissa 0, either sign): load rsp_data = {a_sign^b_sign, all-ones exponent, zero mantissa} and rsp_flags = 4'b0100, then go to RESP. div_start is not pulsed.
  - Otherwise go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle, then go to WAIT. Clear the wait counter.
- WAIT:
  - The counter increments each cycle. Its width is $clog2(TIMEOUT)+1.
  - div_ready=1: capture div_out into rsp_data and rsp_flags = {0,0,div_overflow,div_underflow}, then go to RESP.
  - If the counter reaches TIMEOUT-1 without div_ready: rsp_data = canonical qNaN (0x7FC00000 for X=32, 0x7FF8000000000000 for X=64), rsp_flags = 4'b1000, then go to RESP.
  - If div_ready and the timeout coincide in the same cycle, div_ready wins.
- RESP:
  - rsp_valid=1. rsp_data, rsp_id and rsp_flags stay stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE. A new grant can occur in the next cycle, not the same one.
- div_ready outside WAIT is ignored and must not alter state or outputs.
- reqN_ready is 0 in every state except IDLE. At most one reqN_ready is high per cycle.

## Timing
- Reset (clrn=0, asynchronous): state IDLE, last_grant=1, counter 0. All outputs 0: reqN_ready, div_start, div_a, div_b, rsp_valid, rsp_id, rsp_data, rsp_flags.
- Reset mid-operation: in-flight work is dropped with no response. The divider shares clrn.
- Divider path latency:
  - Accept in cycle 0, div_start in cycle 1.
  - If div_ready arrives in cycle k, rsp_valid rises in cycle k+1.
  - Minimum accept-to-rsp_valid is 3 cycles (div_ready in cycle 2).
- Divide-by-zero path: accept in cycle 0, rsp_valid in cycle 1.
- Timeout path: rsp_valid rises TIMEOUT+1 cycles after div_start.
- Throughput: one operation in flight. The next accept comes no earlier than the cycle after the response handshake.

## Test plan
- Single request: req0 a=0x40C00000 (6.0), b=0x40000000 (2.0); divider model answers 0x40400000 after 5 cycles.
  - Expect div_start one cycle after accept.
  - Expect rsp_valid 1 cycle after div_ready with rsp_id=0, rsp_data=0x40400000, rsp_flags=0.
- Contention: req0 and req1 held valid for 4 operations.
  - Grants must alternate 0,1,0,1.
  - Each reqN_ready is a single-cycle pulse, never both high at once.
- Divide-by-zero: req1 a=0xC0000000, b=0x80000000.
  - Expect rsp_valid the next cycle with rsp_data=0x7F800000, rsp_flags=4'b0100, rsp_id=1.
  - Expect div_start never asserted.
- Timeout: divider never asserts div_ready, TIMEOUT=8.
  - Expect rsp_valid 9 cycles after div_start with rsp_data=0x7FC00000, rsp_flags=4'b1000.
  - Inject a late div_ready in IDLE; state and outputs must be unchanged.
- Backpressure and reset:
  - Hold rsp_ready=0 for 10 cycles; the response must stay stable and no new grant may occur.
  - Then pull clrn low mid-WAIT; all outputs must be 0 immediately and the FSM must be in IDLE after release.
- Flag pass-through: divider returns div_overflow=1 alongside div_out=0x7F800000.
  - Expect rsp_flags=4'b0010 and rsp_data=0x7F800000.

Source files
------------

// File: rtl/fpu_div_scheduler.sv
// fpu_div_scheduler: round-robin share of one multi-cycle FP divider between
// two requesters, with divide-by-zero bypass and a divider timeout.
module fpu_div_scheduler #(
  parameter int unsigned X       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         req0_valid,
  input  logic [X-1:0] req0_a,
  input  logic [X-1:0] req0_b,
  input  logic         req1_valid,
  input  logic [X-1:0] req1_a,
  input  logic [X-1:0] req1_b,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic [X-1:0] div_a,
  output logic [X-1:0] div_b,
  output logic         div_start,
  input  logic         div_ready,
  input  logic [X-1:0] div_out,
  input  logic         div_overflow,
  input  logic         div_underflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [X-1:0] rsp_data,
  output logic [3:0]   rsp_flags
);

  localparam int unsigned EW = (X == 64) ? 11 : 8;
  localparam int unsigned MW = X - 1 - EW;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [X-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [X-1:0]  a_q, a_d, b_q, b_d;
  logic          id_q, id_d;
  logic          start_q, start_d;
  logic          valid_q, valid_d;
  logic [X-1:0]  data_q, data_d;
  logic [3:0]    flags_q, flags_d;

  logic          grant0, grant1, req_any, b_zero;
  logic [X-1:0]  sel_a, sel_b;

  // Round-robin arbitration: on a tie, the requester not granted last wins.
  always_comb begin
    grant0  = req0_valid & (~req1_valid | last_grant_q);
    grant1  = req1_valid & (~req0_valid | ~last_grant_q);
    req_any = req0_valid | req1_valid;
    sel_a   = grant1 ? req1_a : req0_a;
    sel_b   = grant1 ? req1_b : req0_b;
    b_zero  = (sel_b[X-2:0] == '0);
  end

  // Accept strobes are combinational and only ever raised in IDLE, out of reset.
  assign req0_ready = clrn & (state_q == IDLE) & grant0;
  assign req1_ready = clrn & (state_q == IDLE) & grant1;

  assign div_a     = a_q;
  assign div_b     = b_q;
  assign div_start = start_q;
  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_flags = flags_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    start_d      = 1'b0;
    valid_d      = valid_q;
    data_d       = data_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          a_d          = sel_a;
          b_d          = sel_b;
          id_d         = grant1;
          last_grant_d = grant1;
          if (b_zero) begin
            data_d  = {sel_a[X-1] ^ sel_b[X-1], {EW{1'b1}}, {MW{1'b0}}};
            flags_d = 4'b0100;
            valid_d = 1'b1;
            state_d = RESP;
          end else begin
            start_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (div_ready) begin
          data_d  = div_out;
          flags_d = {2'b00, div_overflow, div_underflow};
          valid_d = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d  = QNAN;
          flags_d = 4'b1000;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      start_q      <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      start_q      <= start_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      flags_q      <= flags_d;
    end
  end

endmodule
